// File: rtl/approx_error_sweeper.sv
// Exhaustive error-sweep harness around a combinational approximate circuit and its exact twin.
// Optional FIRST_VIOL_CAPTURE_EN records the tag of the first vector whose error exceeds ET.
module approx_error_sweeper #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int ET    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic [N_IN-1:0]         dut_in,
  input  logic [N_OUT-1:0]        approx_out,
  input  logic [N_OUT-1:0]        exact_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_OUT-1:0]        max_err,
  output logic [N_IN:0]           viol_cnt,
  output logic [N_IN+N_OUT-1:0]   err_sum
`ifdef FIRST_VIOL_CAPTURE_EN
  ,
  output logic [N_IN-1:0]         first_viol_vec,
  output logic                    first_viol_valid
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [N_IN-1:0]       dut_in_q, dut_in_d;
  logic                  cap_vld_q, cap_vld_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [N_OUT-1:0]      max_q, max_d;
  logic [N_IN:0]         viol_q, viol_d;
  logic [N_IN+N_OUT-1:0] sum_q, sum_d;
  logic [N_OUT-1:0]      cap_approx_q, cap_exact_q;
  logic [N_OUT-1:0]      cap_err;
  logic                  is_viol;
  logic [N_OUT-1:0]      max_acc;
  logic [N_IN:0]         viol_acc;
  logic [N_IN+N_OUT-1:0] sum_acc;
`ifdef FIRST_VIOL_CAPTURE_EN
  logic [N_IN-1:0]       cap_tag_q;
  logic [N_IN-1:0]       fv_vec_q, fv_vec_d;
  logic                  fv_vld_q, fv_vld_d;
`endif

  // Capture stage: results for the vector that settled over the last cycle
  always_ff @(posedge clk) begin
    cap_approx_q <= approx_out;
    cap_exact_q  <= exact_out;
`ifdef FIRST_VIOL_CAPTURE_EN
    cap_tag_q    <= dut_in_q;
`endif
  end

  // Accumulate stage: error of the captured pair folded into the running statistics
  always_comb begin
    cap_err  = (cap_exact_q >= cap_approx_q) ? (cap_exact_q - cap_approx_q)
                                             : (cap_approx_q - cap_exact_q);
    is_viol  = (int'(cap_err) > ET);
    max_acc  = (cap_err > max_q) ? cap_err : max_q;
    viol_acc = viol_q + {{N_IN{1'b0}}, is_viol};
    sum_acc  = sum_q + {{N_IN{1'b0}}, cap_err};
  end

  always_comb begin
    state_d   = state_q;
    dut_in_d  = dut_in_q;
    cap_vld_d = 1'b0;
    done_d    = 1'b0;
    pass_d    = pass_q;
    max_d     = max_q;
    viol_d    = viol_q;
    sum_d     = sum_q;
`ifdef FIRST_VIOL_CAPTURE_EN
    fv_vec_d  = fv_vec_q;
    fv_vld_d  = fv_vld_q;
`endif
    case (state_q)
      SWEEP, DRAIN: begin
        if (abort) begin
          state_d  = IDLE;
          dut_in_d = '0;
          pass_d   = 1'b0;
          max_d    = '0;
          viol_d   = '0;
          sum_d    = '0;
`ifdef FIRST_VIOL_CAPTURE_EN
          fv_vec_d = '0;
          fv_vld_d = 1'b0;
`endif
        end else begin
          if (cap_vld_q) begin
            max_d  = max_acc;
            viol_d = viol_acc;
            sum_d  = sum_acc;
`ifdef FIRST_VIOL_CAPTURE_EN
            if (is_viol && !fv_vld_q) begin
              fv_vec_d = cap_tag_q;
              fv_vld_d = 1'b1;
            end
`endif
          end
          if (state_q == SWEEP) begin
            cap_vld_d = 1'b1;
            dut_in_d  = dut_in_q + {{(N_IN-1){1'b0}}, 1'b1};
            if (dut_in_q == {N_IN{1'b1}}) state_d = DRAIN;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (viol_d == '0);
          end
        end
      end
      default: begin
        // IDLE and DONE: a start launches a fresh sweep, abort is irrelevant here
        if (start) begin
          state_d  = SWEEP;
          dut_in_d = '0;
          pass_d   = 1'b0;
          max_d    = '0;
          viol_d   = '0;
          sum_d    = '0;
`ifdef FIRST_VIOL_CAPTURE_EN
          fv_vec_d = '0;
          fv_vld_d = 1'b0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dut_in_q  <= '0;
      cap_vld_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      max_q     <= '0;
      viol_q    <= '0;
      sum_q     <= '0;
`ifdef FIRST_VIOL_CAPTURE_EN
      fv_vec_q  <= '0;
      fv_vld_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dut_in_q  <= dut_in_d;
      cap_vld_q <= cap_vld_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      max_q     <= max_d;
      viol_q    <= viol_d;
      sum_q     <= sum_d;
`ifdef FIRST_VIOL_CAPTURE_EN
      fv_vec_q  <= fv_vec_d;
      fv_vld_q  <= fv_vld_d;
`endif
    end
  end

  assign dut_in   = dut_in_q;
  assign busy     = (state_q == SWEEP) || (state_q == DRAIN);
  assign done     = done_q;
  assign pass     = pass_q;
  assign max_err  = max_q;
  assign viol_cnt = viol_q;
  assign err_sum  = sum_q;
`ifdef FIRST_VIOL_CAPTURE_EN
  assign first_viol_vec   = fv_vec_q;
  assign first_viol_valid = fv_vld_q;
`endif

endmodule

// File: tb/tb_approx_error_sweeper.sv
// Bench for approx_error_sweeper: two instances (ET=3 and ET=1) share stimulus; expected sweep
// results are queued when a sweep is launched and compared when done pulses.
module tb_approx_error_sweeper;

  typedef struct packed {
    logic [1:0] max_e;
    logic [4:0] viol;
    logic [5:0] sum;
    logic       pass;
    logic [3:0] fvv;
    logic       fvvld;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  int         mode = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb3[$];
  exp_t       sb1[$];

  logic [3:0] din3, din1;
  logic [1:0] ex3, ex1, ap3, ap1, max3, max1;
  logic       busy3, busy1, done3, done1, pass3, pass1;
  logic [4:0] viol3, viol1;
  logic [5:0] sum3, sum1;
`ifdef FIRST_VIOL_CAPTURE_EN
  logic [3:0] fvv3, fvv1;
  logic       fvl3, fvl1;
`endif

  always #5 clk = ~clk;

  function automatic logic [1:0] exact_f(input logic [3:0] v);
    logic [1:0] a, b;
    a = v[1:0];
    b = v[3:2];
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic logic [1:0] approx_f(input int m, input logic [3:0] v);
    case (m)
      0:       return exact_f(v);
      1:       return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign ex3 = exact_f(din3);
  assign ap3 = approx_f(mode, din3);
  assign ex1 = exact_f(din1);
  assign ap1 = approx_f(mode, din1);

  approx_error_sweeper #(.N_IN(4), .N_OUT(2), .ET(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_in(din3), .approx_out(ap3), .exact_out(ex3),
    .busy(busy3), .done(done3), .pass(pass3),
    .max_err(max3), .viol_cnt(viol3), .err_sum(sum3)
`ifdef FIRST_VIOL_CAPTURE_EN
    , .first_viol_vec(fvv3), .first_viol_valid(fvl3)
`endif
  );

  approx_error_sweeper #(.N_IN(4), .N_OUT(2), .ET(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_in(din1), .approx_out(ap1), .exact_out(ex1),
    .busy(busy1), .done(done1), .pass(pass1),
    .max_err(max1), .viol_cnt(viol1), .err_sum(sum1)
`ifdef FIRST_VIOL_CAPTURE_EN
    , .first_viol_vec(fvv1), .first_viol_valid(fvl1)
`endif
  );

  // Reference results over the first n vectors of a sweep
  function automatic exp_t model(input int m, input int et, input int n);
    exp_t r;
    int   e, mx, vc, sm;
    logic [3:0] vv;
    r  = '0;
    mx = 0; vc = 0; sm = 0;
    for (int v = 0; v < n; v++) begin
      vv = 4'(v);
      e  = int'(exact_f(vv)) - int'(approx_f(m, vv));
      if (e < 0) e = -e;
      if (e > mx) mx = e;
      if (e > et) begin
        vc++;
        if (!r.fvvld) begin
          r.fvvld = 1'b1;
          r.fvv   = vv;
        end
      end
      sm += e;
    end
    r.max_e = 2'(mx);
    r.viol  = 5'(vc);
    r.sum   = 6'(sm);
    r.pass  = (vc == 0);
    return r;
  endfunction

  task automatic run_sweep(input int m, input bit seq_chk);
    int   n;
    bit   got;
    exp_t e;
    logic [3:0] exp_din;
    mode = m;
    sb3.push_back(model(m, 3, 16));
    sb1.push_back(model(m, 1, 16));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy3 !== 1'b1 || din3 !== 4'd0 || sum3 !== 6'd0 || max3 !== 2'd0 ||
        viol3 !== 5'd0 || pass3 !== 1'b0 || sum1 !== 6'd0 || viol1 !== 5'd0)
      begin
      errors++;
      $display("FAIL sweep_start: busy=%0b din=%0d sum=%0d max=%0d viol=%0d pass=%0b sum1=%0d viol1=%0d, expected busy=1 and all else 0",
               busy3, din3, sum3, max3, viol3, pass3, sum1, viol1);
    end
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (seq_chk && n <= 17) begin
        exp_din = (n >= 16) ? 4'd0 : 4'(n);
        checks++;
        if (din3 !== exp_din) begin
          errors++;
          $display("FAIL dut_in_seq edge %0d: got %0d expected %0d", n, din3, exp_din);
        end
      end
      if (done3 === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || n != 17 || done1 !== 1'b1 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL done_latency: got=%0b edges=%0d done1=%0b busy=%0b, expected done after 17 edges with busy=0",
               got, n, done1, busy3);
    end
    e = sb3.pop_front();
    if (got) begin
      checks++;
      if (max3 !== e.max_e || viol3 !== e.viol || sum3 !== e.sum || pass3 !== e.pass) begin
        errors++;
        $display("FAIL results_et3: max=%0d viol=%0d sum=%0d pass=%0b expected max=%0d viol=%0d sum=%0d pass=%0b",
                 max3, viol3, sum3, pass3, e.max_e, e.viol, e.sum, e.pass);
      end
`ifdef FIRST_VIOL_CAPTURE_EN
      checks++;
      if (fvv3 !== e.fvv || fvl3 !== e.fvvld) begin
        errors++;
        $display("FAIL first_viol_et3: vec=%0d valid=%0b expected vec=%0d valid=%0b", fvv3, fvl3, e.fvv, e.fvvld);
      end
`endif
    end
    e = sb1.pop_front();
    if (got) begin
      checks++;
      if (max1 !== e.max_e || viol1 !== e.viol || sum1 !== e.sum || pass1 !== e.pass) begin
        errors++;
        $display("FAIL results_et1: max=%0d viol=%0d sum=%0d pass=%0b expected max=%0d viol=%0d sum=%0d pass=%0b",
                 max1, viol1, sum1, pass1, e.max_e, e.viol, e.sum, e.pass);
      end
`ifdef FIRST_VIOL_CAPTURE_EN
      checks++;
      if (fvv1 !== e.fvv || fvl1 !== e.fvvld) begin
        errors++;
        $display("FAIL first_viol_et1: vec=%0d valid=%0b expected vec=%0d valid=%0b", fvv1, fvl1, e.fvv, e.fvvld);
      end
`endif
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (din3 !== 4'd0 || busy3 !== 1'b0 || done3 !== 1'b0 || pass3 !== 1'b0 ||
        max3 !== 2'd0 || viol3 !== 5'd0 || sum3 !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: din=%0d busy=%0b done=%0b pass=%0b max=%0d viol=%0d sum=%0d, expected all 0",
               din3, busy3, done3, pass3, max3, viol3, sum3);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy3 !== 1'b0 || din3 !== 4'd0 || done3 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%0b din=%0d done=%0b expected 0 0 0", busy3, din3, done3);
    end
  endtask

  task automatic test_done_hold();
    @(posedge clk); #1;
    checks++;
    if (done3 !== 1'b0 || busy3 !== 1'b0 || din3 !== 4'd0 || pass3 !== 1'b1 || sum3 !== 6'd28) begin
      errors++;
      $display("FAIL done_hold: done=%0b busy=%0b din=%0d pass=%0b sum=%0d expected 0 0 0 1 28",
               done3, busy3, din3, pass3, sum3);
    end
  endtask

  task automatic test_abort();
    int   k;
    bit   bad;
    exp_t p;
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    k = 0;
    bad = 1'b0;
    while (din3 !== 4'd7 && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (din3 !== 4'(k)) bad = 1'b1;
    end
    checks++;
    if (bad || k != 7 || busy3 !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored_busy: edges=%0d busy=%0b din=%0d expected monotonic run to 7 in 7 edges", k, busy3, din3);
    end
    p = model(1, 3, 6);
    checks++;
    if (sum3 !== p.sum || max3 !== p.max_e) begin
      errors++;
      $display("FAIL partial_stats: sum=%0d max=%0d expected sum=%0d max=%0d", sum3, max3, p.sum, p.max_e);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy3 !== 1'b0 || din3 !== 4'd0 || done3 !== 1'b0 || sum3 !== 6'd0 || max3 !== 2'd0 ||
        viol3 !== 5'd0 || viol1 !== 5'd0 || pass3 !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%0b din=%0d done=%0b sum=%0d max=%0d viol=%0d viol1=%0d pass=%0b expected all 0",
               busy3, din3, done3, sum3, max3, viol3, viol1, pass3);
    end
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done3 !== 1'b0 || busy3 !== 1'b0 || done1 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL abort_no_done: done or busy rose after abort, expected both 0 for 20 cycles");
    end
  endtask

  task automatic test_async_reset();
    int k;
    mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (din3 !== 4'd9 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (k != 9 || din3 !== 4'd0 || busy3 !== 1'b0 || done3 !== 1'b0 || pass3 !== 1'b0 ||
        max3 !== 2'd0 || viol3 !== 5'd0 || sum3 !== 6'd0 || sum1 !== 6'd0 || din1 !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: edges=%0d din=%0d busy=%0b done=%0b pass=%0b max=%0d viol=%0d sum=%0d sum1=%0d expected 9 then all 0",
               k, din3, busy3, done3, pass3, max3, viol3, sum3, sum1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_sweep(1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b1);
  endtask

  initial begin
    test_reset();
    run_sweep(0, 1'b1);
    @(posedge clk); #1;
    run_sweep(1, 1'b0);
    test_done_hold();
    test_abort();
    test_async_reset();
    test_back_to_back();
    @(posedge clk); #1;
    checks++;
    if (done3 !== 1'b0 || sum3 !== 6'd20 || max3 !== 2'd3 || din3 !== 4'd0) begin
      errors++;
      $display("FAIL final_hold: done=%0b sum=%0d max=%0d din=%0d expected 0 20 3 0", done3, sum3, max3, din3);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
